// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: IF/ID-side head presentation, redirect input and
// instruction-memory req/ack handshake grouped into one bundle.
interface instr_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Fetch queue side
  modport master (
    input  redirect_valid, redirect_pc, if_ready, mem_ack, mem_rdata,
    output if_valid, if_instr, if_pc, if_pc_plus4, mem_req, mem_addr
  );

  // Pipeline / memory side
  modport slave (
    output redirect_valid, redirect_pc, if_ready, mem_ack, mem_rdata,
    input  if_valid, if_instr, if_pc, if_pc_plus4, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Prefetch queue between variable-latency instruction memory and IF/ID.
// Holds up to DEPTH {pc, instr} entries, one request outstanding at most,
// flushes and refetches on branch/jump redirect.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t            state, state_next;
  logic [31:0]       fetch_pc;
  logic [31:0]       req_addr;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count, count_next;
  logic [31:0]       pc_q    [DEPTH];
  logic [31:0]       instr_q [DEPTH];
  logic              redirect, push, pop, credit, head_valid;

  assign redirect   = bus.redirect_valid;
  assign head_valid = (count != '0);
  // Redirect voids both the push of returning data and any pop this cycle
  assign push       = (state == REQ) && bus.mem_ack && !redirect;
  assign pop        = head_valid && bus.if_ready && !redirect;

  // Occupancy after this edge, and whether another request fits behind it
  always_comb begin
    count_next = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    credit     = (count_next < FULL);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!redirect && credit) state_next = REQ;
      // Redirect with ack: returned word is dropped and the flushed queue
      // always has room, so the new target is requested without a DRAIN.
      REQ:   if (bus.mem_ack)   state_next = (redirect || credit) ? REQ : IDLE;
             else if (redirect) state_next = DRAIN;
      DRAIN: if (bus.mem_ack)   state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: DRAIN keeps presenting the abandoned address until ack
  always_comb begin
    bus.mem_req  = (state != IDLE);
    bus.mem_addr = (state == DRAIN) ? req_addr : fetch_pc;
  end

  // Fetch pointer, queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (state == REQ) req_addr <= fetch_pc;
      if (redirect) begin
        fetch_pc <= bus.redirect_pc & ~32'd3;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + 32'd4;
          wr_ptr   <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_next;
      end
    end
  end

  // Entry storage, written on push only
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= fetch_pc;
      instr_q[wr_ptr] <= bus.mem_rdata;
    end
  end

  // Head presentation, zeroed when empty so reset state reads 0 / pc+4 = 4
  always_comb begin
    bus.if_valid    = head_valid;
    bus.if_pc       = head_valid ? pc_q[rd_ptr]    : '0;
    bus.if_instr    = head_valid ? instr_q[rd_ptr] : '0;
    bus.if_pc_plus4 = bus.if_pc + 32'd4;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a per-cycle vector table covering
// streaming, backpressure, redirects, wrap and reset, then a variable-latency
// ordering sequence.
module tb_instr_fetch_queue;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic rst, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ack, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ack = ack;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          pops;
    int          wait_cnt;
    int          lat;
    logic [31:0] exp_pc;
    logic [31:0] epc;

    //              rst rv  rpc           rdy ack req  addr          vld  pc
    // 0-wait streaming from reset
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0000_0004, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0000_0008, 1, 32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0000_000C, 1, 32'h8));
    // reset while request pending, late ack ignored
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 32'h0000_0010, 1, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0000, 0, 32'h0));
    // if_ready=0: exactly four pushes, then mem_req stays low
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h0000_0004, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h0000_0008, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h0000_000C, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 32'h0));
    // drain in order; request re-issued once space frees, address held
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0000_0010, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h0000_0010, 1, 32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h0000_0010, 1, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h0000_0010, 1, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h0000_0010, 0, 32'h0));
    // redirect during wait -> DRAIN on stale address, word dropped
    vecs.push_back(mk(0, 1, 32'h100,      1, 0, 1, 32'h0000_0010, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h0000_0010, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0000_0010, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h0000_0100, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h0000_0100, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0000_0100, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h0000_0104, 1, 32'h100));
    // redirect with ack same cycle (low bits ignored), no DRAIN
    vecs.push_back(mk(0, 1, 32'h203,      1, 1, 1, 32'h0000_0104, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFF8, 1, 1, 1, 32'h0000_0200, 0, 32'h0));
    // wrap through 0xFFFF_FFFC -> 0
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0000_0004, 1, 32'h0));
    // redirect flushes non-empty queue, then retarget while draining
    vecs.push_back(mk(0, 1, 32'h40,       1, 0, 1, 32'h0000_0008, 1, 32'h4));
    vecs.push_back(mk(0, 1, 32'h80,       1, 0, 1, 32'h0000_0008, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0000_0008, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h0000_0080, 0, 32'h0));

    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;
    bus.mem_ack        = 1'b0;
    bus.mem_rdata      = '0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset              = vecs[i].rst;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      bus.if_ready       = vecs[i].rdy;
      bus.mem_ack        = vecs[i].ack;
      bus.mem_rdata      = instr_of(vecs[i].e_addr);
      @(negedge clk);
      epc = vecs[i].e_pc;
      chk($sformatf("row%0d mem_req", i),     32'(bus.mem_req),  32'(vecs[i].e_req));
      chk($sformatf("row%0d mem_addr", i),    bus.mem_addr,      vecs[i].e_addr);
      chk($sformatf("row%0d if_valid", i),    32'(bus.if_valid), 32'(vecs[i].e_valid));
      chk($sformatf("row%0d if_pc", i),       bus.if_pc,         epc);
      chk($sformatf("row%0d if_instr", i),    bus.if_instr,
          vecs[i].e_valid ? instr_of(epc) : 32'h0);
      chk($sformatf("row%0d if_pc_plus4", i), bus.if_pc_plus4,   epc + 32'd4);
    end

    // Variable-latency memory (0,1,2 wait cycles rotating) with random
    // if_ready: entries must leave in fetch order from RESET_PC.
    @(posedge clk);
    #1;
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.mem_ack        = 1'b0;
    bus.if_ready       = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    pops     = 0;
    wait_cnt = 0;
    lat      = 0;
    exp_pc   = 32'h0;
    for (int cyc = 0; cyc < 400 && pops < 16; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        if (wait_cnt == lat) begin
          bus.mem_ack = 1'b1;
          wait_cnt    = 0;
          lat         = (lat + 1) % 3;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
      bus.mem_rdata = instr_of(bus.mem_addr);
      bus.if_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.if_valid && bus.if_ready) begin
        chk($sformatf("order%0d if_pc", pops),       bus.if_pc,       exp_pc);
        chk($sformatf("order%0d if_instr", pops),    bus.if_instr,    instr_of(exp_pc));
        chk($sformatf("order%0d if_pc_plus4", pops), bus.if_pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    checks++;
    if (pops < 16) begin
      errors++;
      $display("FAIL order_timeout: got %0d pops required 16", pops);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
